// File: rtl/fpacc_ctrl.sv
// fpacc_ctrl: sequences a stream of IEEE-754 single operands through an
// external combinational fp adder, accumulating N operands into one result.
// Zero operands and loads into an empty accumulator bypass the adder.
module fpacc_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk_x40,
    input  logic             rstn_x40,
    input  logic             start_x40,
    input  logic [CNT_W-1:0] len_x40,
    input  logic             in_valid_x40,
    input  logic [31:0]      in_data_x40,
    output logic             in_ready_x40,
    output logic [31:0]      add_a_x40,
    output logic [31:0]      add_b_x40,
    input  logic [31:0]      add_sum_x40,
    output logic             out_valid_x40,
    output logic [31:0]      out_data_x40,
    input  logic             out_ready_x40,
    output logic             busy_x40
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCEPT,
        S_ADD,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      acc_q, acc_d;
    logic [31:0]      b_reg_q, b_reg_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             first_q, first_d;

    logic acc_zero;
    logic op_zero;
    logic last_op;

    assign acc_zero = (acc_q[30:0] == 31'd0);
    assign op_zero  = (in_data_x40[30:0] == 31'd0);
    // remaining is never 0 while accepting, so the decrement cannot wrap.
    assign last_op  = (remaining_q == CNT_W'(1));

    // Next-state and datapath update for the accumulation sequence.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        acc_d       = acc_q;
        b_reg_d     = b_reg_q;
        remaining_d = remaining_q;
        first_d     = first_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_x40) begin
                    remaining_d = len_x40;
                    if (len_x40 == '0) begin
                        acc_d   = 32'd0;
                        state_d = S_DONE;
                    end else begin
                        first_d = 1'b1;
                        state_d = S_ACCEPT;
                    end
                end
            end
            S_ACCEPT: begin
                if (in_valid_x40) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    first_d     = 1'b0;
                    if (first_q || acc_zero) begin
                        acc_d   = in_data_x40;
                        state_d = last_op ? S_DONE : S_ACCEPT;
                    end else if (op_zero) begin
                        state_d = last_op ? S_DONE : S_ACCEPT;
                    end else begin
                        b_reg_d = in_data_x40;
                        state_d = S_ADD;
                    end
                end
            end
            S_ADD: begin
                acc_d   = add_sum_x40;
                state_d = (remaining_q == '0) ? S_DONE : S_ACCEPT;
            end
            S_DONE: begin
                if (out_ready_x40) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous reset taking priority over all updates.
    always_ff @(posedge clk_x40) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rstn_x40) begin
            // NOTE: all registers here are control/datapath flops, not a memory
            // array, so each one is cleared to give defined outputs in reset.
            state_q     <= S_IDLE;
            acc_q       <= 32'd0;
            b_reg_q     <= 32'd0;
            remaining_q <= '0;
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            b_reg_q     <= b_reg_d;
            remaining_q <= remaining_d;
            first_q     <= first_d;
        end
    end

    assign in_ready_x40  = (state_q == S_ACCEPT);
    assign out_valid_x40 = (state_q == S_DONE);
    assign busy_x40      = (state_q != S_IDLE);
    assign out_data_x40  = acc_q;
    assign add_a_x40     = acc_q;
    assign add_b_x40     = b_reg_q;

endmodule

// File: tb/tb_fpacc_ctrl.sv
// tb_fpacc_ctrl: directed self-checking bench for fpacc_ctrl with a behavioural
// adder that is either a small fp lookup or a plain integer add of bit patterns.
module tb_fpacc_ctrl;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rstn;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic [31:0]      in_data;
    logic             in_ready;
    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic [31:0]      add_sum;
    logic             out_valid;
    logic [31:0]      out_data;
    logic             out_ready;
    logic             busy;

    int total = 0;
    int bad   = 0;

    logic        use_fp = 1'b0;
    logic [31:0] ops [256];
    logic [31:0] pa  [4];
    logic [31:0] pb  [4];

    fpacc_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_x40      (clk),
        .rstn_x40     (rstn),
        .start_x40    (start),
        .len_x40      (len),
        .in_valid_x40 (in_valid),
        .in_data_x40  (in_data),
        .in_ready_x40 (in_ready),
        .add_a_x40    (add_a),
        .add_b_x40    (add_b),
        .add_sum_x40  (add_sum),
        .out_valid_x40(out_valid),
        .out_data_x40 (out_data),
        .out_ready_x40(out_ready),
        .busy_x40     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Only the fp sums the directed vectors need; anything else is flagged.
    function automatic logic [31:0] fp_lut(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        if (a == 32'h4040_0000 && b == 32'h4080_0000) return 32'h40E0_0000;
        return 32'hDEAD_BEEF;
    endfunction

    assign add_sum = use_fp ? fp_lut(add_a, add_b) : add_a + add_b;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one accumulation from ops[]; returns edges until out_valid (start
    // edge = 1), result, ADD-cycle count, in_ready cycle count, timeout flag.
    task automatic drive_run(input int n, input bit gaps, output int edges,
                             output logic [31:0] data, output int adds,
                             output int rdy_cycles, output bit timeout);
        int idx;
        bit xfer;
        idx = 0; edges = 0; adds = 0; rdy_cycles = 0; timeout = 1'b0; data = '0;
        start    = 1'b1;
        len      = n[CNT_W-1:0];
        in_data  = ops[0];
        in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        forever begin
            xfer = in_ready && in_valid;
            tick();
            edges++;
            start = 1'b0;
            if (xfer) idx++;
            if (in_ready) rdy_cycles++;
            if (out_valid) begin
                data = out_data;
                break;
            end
            if (busy && !in_ready) begin
                if (adds < 4) begin
                    pa[adds] = add_a;
                    pb[adds] = add_b;
                end
                adds++;
            end
            if (idx < 256) in_data = ops[idx];
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            if (edges > 3000) begin
                timeout = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b1;
        tick(); tick();
        total++;
        if ({out_valid, in_ready, busy} !== 3'b000) begin
            bad++; $display("FAIL reset_ctrl: got %b want 000", {out_valid, in_ready, busy});
        end
        total++;
        if (add_a !== 32'd0) begin bad++; $display("FAIL reset_add_a: got %h want 0", add_a); end
        total++;
        if (add_b !== 32'd0) begin bad++; $display("FAIL reset_add_b: got %h want 0", add_b); end
        total++;
        if (out_data !== 32'd0) begin bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int e, a, r; logic [31:0] d; bit to;
        use_fp = 1'b1;
        ops[0] = 32'h3F80_0000;
        drive_run(1, 1'b0, e, d, a, r, to);
        total++;
        if (to || e !== 2) begin bad++; $display("FAIL single_latency: got %0d want 2", e); end
        total++;
        if (d !== 32'h3F80_0000) begin bad++; $display("FAIL single_data: got %h want 3f800000", d); end
        total++;
        if (a !== 0) begin bad++; $display("FAIL single_no_add: got %0d want 0", a); end
        tick();
    endtask

    task automatic test_three_add();
        int e, a, r; logic [31:0] d; bit to;
        use_fp = 1'b1;
        ops[0] = 32'h3F80_0000; ops[1] = 32'h4000_0000; ops[2] = 32'h4080_0000;
        drive_run(3, 1'b0, e, d, a, r, to);
        total++;
        if (to || e !== 6) begin bad++; $display("FAIL three_latency: got %0d want 6", e); end
        total++;
        if (d !== 32'h40E0_0000) begin bad++; $display("FAIL three_data: got %h want 40e00000", d); end
        total++;
        if (a !== 2) begin bad++; $display("FAIL three_add_count: got %0d want 2", a); end
        total++;
        if (pa[0] !== 32'h3F80_0000 || pb[0] !== 32'h4000_0000) begin
            bad++; $display("FAIL three_pair0: got %h,%h want 3f800000,40000000", pa[0], pb[0]);
        end
        total++;
        if (pa[1] !== 32'h4040_0000 || pb[1] !== 32'h4080_0000) begin
            bad++; $display("FAIL three_pair1: got %h,%h want 40400000,40800000", pa[1], pb[1]);
        end
        tick();
    endtask

    task automatic test_zero_len();
        int e, a, r; logic [31:0] d; bit to;
        drive_run(0, 1'b0, e, d, a, r, to);
        total++;
        if (to || e !== 1) begin bad++; $display("FAIL zero_len_latency: got %0d want 1", e); end
        total++;
        if (d !== 32'd0) begin bad++; $display("FAIL zero_len_data: got %h want 0", d); end
        total++;
        if (r !== 0) begin bad++; $display("FAIL zero_len_ready: got %0d want 0", r); end
        tick();
    endtask

    task automatic test_zero_ops();
        int e, a, r; logic [31:0] d; bit to;
        use_fp = 1'b1;
        ops[0] = 32'h0000_0000; ops[1] = 32'h3F80_0000; ops[2] = 32'h8000_0000;
        drive_run(3, 1'b0, e, d, a, r, to);
        total++;
        if (a !== 0) begin bad++; $display("FAIL zero_ops_no_add: got %0d want 0", a); end
        total++;
        if (to || e !== 4) begin bad++; $display("FAIL zero_ops_latency: got %0d want 4", e); end
        total++;
        if (d !== 32'h3F80_0000) begin bad++; $display("FAIL zero_ops_data: got %h want 3f800000", d); end
        tick();
    endtask

    task automatic test_backpressure();
        int e, a, r; logic [31:0] d; bit to;
        use_fp = 1'b0;
        ops[0] = 32'd5; ops[1] = 32'd6;
        out_ready = 1'b0;
        drive_run(2, 1'b1, e, d, a, r, to);
        total++;
        if (to || d !== 32'd11) begin bad++; $display("FAIL bp_gap_data: got %h want 0000000b", d); end
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            len   = 8'd1;
            tick();
            total++;
            if (out_valid !== 1'b1 || out_data !== 32'd11) begin
                bad++; $display("FAIL bp_hold_%0d: got v=%b d=%h want v=1 d=0000000b", i, out_valid, out_data);
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_release: got busy=%b v=%b want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_max_len();
        int e, a, r; logic [31:0] d; bit to;
        use_fp = 1'b0;
        for (int i = 0; i < 256; i++) ops[i] = 32'd1;
        drive_run(255, 1'b0, e, d, a, r, to);
        total++;
        if (to || e !== 510) begin bad++; $display("FAIL max_latency: got %0d want 510", e); end
        total++;
        if (d !== 32'd255) begin bad++; $display("FAIL max_data: got %h want 000000ff", d); end
        tick();
    endtask

    task automatic test_reset_in_add();
        int guard; int pulses;
        use_fp = 1'b0;
        start = 1'b1; len = 8'd3; in_valid = 1'b1; in_data = 32'd1;
        tick();
        start = 1'b0;
        guard = 0;
        while (!(busy && !in_ready && !out_valid) && guard < 20) begin
            in_data = 32'd2;
            tick();
            guard++;
        end
        total++;
        if (guard >= 20) begin bad++; $display("FAIL rst_add_reach: got %0d cycles want <20", guard); end
        rstn = 1'b0; start = 1'b1; len = 8'd2;
        tick();
        total++;
        if ({busy, out_valid, in_ready} !== 3'b000 || add_a !== 32'd0 || add_b !== 32'd0 || out_data !== 32'd0) begin
            bad++; $display("FAIL rst_add_outputs: got b=%b v=%b r=%b a=%h b=%h d=%h want all 0",
                            busy, out_valid, in_ready, add_a, add_b, out_data);
        end
        rstn = 1'b1; start = 1'b0; in_valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid || busy) pulses++;
        end
        total++;
        if (pulses !== 0) begin bad++; $display("FAIL rst_add_no_pulse: got %0d want 0", pulses); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_three_add();
        test_zero_len();
        test_zero_ops();
        test_backpressure();
        test_max_len();
        test_reset_in_add();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
